// File: rtl/magnitude_comparator_if.sv
// Operand/result bundle for the registered magnitude comparator.
// The master side presents operands and mode; the slave side returns the
// registered relation flags.
interface magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             greater;
   logic             lesser;
   logic             equal;

   modport master (
      output in_valid, signed_mode, a, b,
      input  out_valid, greater, lesser, equal
   );

   modport slave (
      input  in_valid, signed_mode, a, b,
      output out_valid, greater, lesser, equal
   );
endinterface

// File: rtl/magnitude_comparator.sv
// Registered N-bit magnitude comparator.
// A combinational unsigned/two's-complement compare feeds one register stage;
// results appear one cycle after a qualified input. Flags hold across idle
// cycles so the last result stays readable while out_valid is low.
module magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input logic                    clk,
   input logic                    rst,
   magnitude_comparator_if.slave  bus
);
   localparam int MSB = WIDTH - 1;

   logic w_equal;
   logic w_sign_differs;
   logic w_a_greater;
   logic w_a_lesser;

   logic r_out_valid;
   logic r_greater;
   logic r_lesser;
   logic r_equal;

   // Relation of the presented operands. With equal sign bits the full-width
   // unsigned compare orders them correctly (the MSBs cancel); with differing
   // signs in signed mode, the non-negative operand (MSB=0) is the greater one.
   always_comb begin
      w_equal        = (bus.a == bus.b);
      w_sign_differs = bus.signed_mode && (bus.a[MSB] != bus.b[MSB]);
      if (w_sign_differs) begin
         w_a_greater = ~bus.a[MSB];
      end else begin
         w_a_greater = (bus.a > bus.b);
      end
      w_a_lesser = ~w_a_greater && ~w_equal;
   end

   // Result register: capture flags on accepted operations, drop out_valid on idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_greater   <= 1'b0;
         r_lesser    <= 1'b0;
         r_equal     <= 1'b0;
      end else if (bus.in_valid) begin
         r_out_valid <= 1'b1;
         r_greater   <= w_a_greater;
         r_lesser    <= w_a_lesser;
         r_equal     <= w_equal;
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.greater   = r_greater;
   assign bus.lesser    = r_lesser;
   assign bus.equal     = r_equal;
endmodule

// File: tb/tb_magnitude_comparator.sv
// Testbench for magnitude_comparator: directed cases plus randomized traffic.
// Expected flags come from an integer-valued reference model and are queued
// by the driver; a separate monitor pops and compares on every out_valid.
module tb_magnitude_comparator;
   localparam int W = 8;

   typedef struct {
      logic         g;
      logic         l;
      logic         e;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sm;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n_out;
   exp_t sb_q[$];

   magnitude_comparator_if #(.WIDTH(W)) bus ();

   magnitude_comparator #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: interpret the operands as plain integers and order them.
   function automatic longint to_int(input logic [W-1:0] v, input logic sm);
      longint r;
      r = longint'(v);
      if (sm && v[W-1]) r = r - (longint'(1) << W);
      return r;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sm);
      exp_t   x;
      longint va;
      longint vb;
      va   = to_int(a, sm);
      vb   = to_int(b, sm);
      x.g  = (va > vb);
      x.l  = (va < vb);
      x.e  = (va == vb);
      x.a  = a;
      x.b  = b;
      x.sm = sm;
      return x;
   endfunction

   // Present one operation for the coming edge and record its expected result.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.a           = a;
      bus.b           = b;
      bus.signed_mode = sm;
      sb_q.push_back(model(a, b, sm));
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid    = 1'b0;
      bus.a           = W'($urandom);
      bus.b           = W'($urandom);
      bus.signed_mode = 1'($urandom);
   endtask

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got v/g/l/e=%b want %b", name, got, want);
      end
   endtask

   // Monitor: one line per completed transaction, compared against the queue head.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) begin
            n_out++;
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: out_valid=1 with g/l/e=%b%b%b and no operation pending",
                        bus.greater, bus.lesser, bus.equal);
            end else begin
               x = sb_q.pop_front();
               if ({bus.greater, bus.lesser, bus.equal} !== {x.g, x.l, x.e}) begin
                  bad++;
                  $display("FAIL sb_flags: a=%h b=%h sm=%b got g/l/e=%b%b%b want %b%b%b",
                           x.a, x.b, x.sm, bus.greater, bus.lesser, bus.equal, x.g, x.l, x.e);
               end else begin
                  $display("txn a=%h b=%h sm=%b g/l/e=%b%b%b ok",
                           x.a, x.b, x.sm, bus.greater, bus.lesser, bus.equal);
               end
            end
         end
      end
   end

   logic [W-1:0] ua [6] = '{8'h52, 8'h6D, 8'hB1, 8'h5E, 8'h6C, 8'hD8};
   logic [W-1:0] ub [6] = '{8'hAA, 8'h4B, 8'hB2, 8'h5B, 8'h6C, 8'hD6};
   logic [W-1:0] sa [6] = '{8'h52, 8'h80, 8'hFF, 8'hD8, 8'h00, 8'h00};
   logic [W-1:0] sb [6] = '{8'hAA, 8'h7F, 8'hFF, 8'hD6, 8'hFF, 8'h00};

   initial begin
      total = 0;
      bad   = 0;
      n_out = 0;
      rst             = 1'b1;
      bus.in_valid    = 1'b1;
      bus.a           = 8'hFF;
      bus.b           = 8'h00;
      bus.signed_mode = 1'b0;

      // Reset holds outputs clear even with a valid operation presented.
      repeat (3) @(posedge clk);
      #2;
      check("reset_state", {bus.out_valid, bus.greater, bus.lesser, bus.equal}, 4'b0000);

      // Release reset with the operation still presented: next edge gives greater.
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back(model(8'hFF, 8'h00, 1'b0));
      @(posedge clk);
      #2;
      check("after_reset", {bus.out_valid, bus.greater, bus.lesser, bus.equal}, 4'b1100);

      // Back-to-back unsigned sequence.
      for (int i = 0; i < 6; i++) issue(ua[i], ub[i], 1'b0);
      // Signed cases and boundaries, then the boundary pairs unsigned.
      for (int i = 0; i < 6; i++) issue(sa[i], sb[i], 1'b1);
      issue(8'h00, 8'hFF, 1'b0);
      issue(8'h00, 8'h00, 1'b0);

      // Hold: last accepted result is equal, then three idle cycles.
      issue(8'h6C, 8'h6C, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         @(posedge clk);
         #2;
         check($sformatf("hold_%0d", i), {bus.out_valid, bus.greater, bus.lesser, bus.equal}, 4'b0001);
      end

      // Randomized traffic with idle gaps.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) idle();
         else issue(W'($urandom), W'($urandom), 1'($urandom));
      end
      idle();
      @(posedge clk);

      // Mid-stream reset: clears outputs with no clock edge involved.
      issue(8'h6D, 8'h4B, 1'b1);
      @(posedge clk);
      #2;
      check("pre_async_rst", {bus.out_valid, bus.greater, bus.lesser, bus.equal}, 4'b1100);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst", {bus.out_valid, bus.greater, bus.lesser, bus.equal}, 4'b0000);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d operations never produced out_valid, want 0", sb_q.size());
      end
      total++;
      if (n_out != 317 - 0 && n_out < 16) begin
         bad++;
         $display("FAIL out_count: saw %0d results, want at least 16", n_out);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
